// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage: accepts WIDTH-bit words over valid/ready and
// shifts them out one bit per clock, with optional idle gap and abort.
module bit_serializer #(
    parameter int WIDTH      = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int GAP        = 0,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             abort,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int              CNT_W        = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT    = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] PENULT_BIT  = CNT_W'(WIDTH - 2);
    localparam logic [3:0]      GAP_LAST     = 4'(GAP - 1);
    localparam bit              BACK_TO_BACK = (GAP == 0);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [3:0]       r_gap_cnt;
    logic [WIDTH-1:0] r_shreg;
    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_word_done;
    logic             r_busy;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_bit_cnt_nxt;
    logic [3:0]       w_gap_cnt_nxt;
    logic [WIDTH-1:0] w_shreg_nxt;
    logic             w_ser_out_nxt;
    logic             w_ser_valid_nxt;
    logic             w_word_done_nxt;
    logic             w_last_bit;
    logic             w_accept;

    // The shift register always holds the not-yet-sent bits with the next one at its head.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? (w << 1) : (w >> 1);
    endfunction

    assign w_last_bit = (r_state == S_SHIFT) && (r_bit_cnt == LAST_BIT);
    assign din_ready  = (r_state == S_IDLE) || (BACK_TO_BACK && w_last_bit && !abort);
    assign w_accept   = din_valid && din_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path can leave it unassigned (no latches).
        w_state_nxt     = r_state;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_gap_cnt_nxt   = r_gap_cnt;
        w_shreg_nxt     = r_shreg;
        w_ser_out_nxt   = IDLE_LEVEL;
        w_ser_valid_nxt = 1'b0;
        w_word_done_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt     = S_SHIFT;
                    w_bit_cnt_nxt   = '0;
                    w_ser_out_nxt   = head_bit(din);
                    w_shreg_nxt     = drop_head(din);
                    w_ser_valid_nxt = 1'b1;
                end
            end

            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt   = S_IDLE;
                    w_bit_cnt_nxt = '0;
                    w_shreg_nxt   = '0;
                end else if (w_last_bit) begin
                    w_bit_cnt_nxt = '0;
                    if (w_accept) begin
                        w_state_nxt     = S_SHIFT;
                        w_ser_out_nxt   = head_bit(din);
                        w_shreg_nxt     = drop_head(din);
                        w_ser_valid_nxt = 1'b1;
                    end else if (!BACK_TO_BACK) begin
                        w_state_nxt   = S_GAP;
                        w_gap_cnt_nxt = '0;
                        w_shreg_nxt   = '0;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_shreg_nxt = '0;
                    end
                end else begin
                    w_bit_cnt_nxt   = r_bit_cnt + 1'b1;
                    w_ser_out_nxt   = head_bit(r_shreg);
                    w_shreg_nxt     = drop_head(r_shreg);
                    w_ser_valid_nxt = 1'b1;
                    w_word_done_nxt = (r_bit_cnt == PENULT_BIT);
                end
            end

            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt   = S_IDLE;
                    w_gap_cnt_nxt = '0;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 4'd1;
                end
            end

            default: begin
                w_state_nxt   = S_IDLE;
                w_bit_cnt_nxt = '0;
                w_gap_cnt_nxt = '0;
                w_shreg_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bit_cnt   <= '0;
            r_gap_cnt   <= '0;
            r_shreg     <= '0;
            r_ser_out   <= IDLE_LEVEL;
            r_ser_valid <= 1'b0;
            r_word_done <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values.
            r_state     <= w_state_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_gap_cnt   <= w_gap_cnt_nxt;
            r_shreg     <= w_shreg_nxt;
            r_ser_out   <= w_ser_out_nxt;
            r_ser_valid <= w_ser_valid_nxt;
            r_word_done <= w_word_done_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign word_done = r_word_done;
    assign busy      = r_busy;

endmodule
